clk_enable_gen: RTL and testbench

CLK_ENABLE_GEN -- requirements
Module: clk_enable_gen

---
 rtl/clk_enable_gen.sv | 108 ++++++++++
 tb/tb_clk_enable_gen.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_enable_gen.sv
// Multi-channel programmable clock-enable generator.
// Each channel emits a one-cycle tick every act cycles plus a half-rate square wave.
module clk_enable_gen #(
  parameter int NCH = 3,
  parameter int W = 26,
  parameter logic [NCH*W-1:0] DIV_INIT =
    {26'd33554432, 26'd131072, 26'd2}
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run_i,
  input  logic           sync_i,
  input  logic           wr_en_i,
  input  logic [2:0]     wr_ch_i,
  input  logic [W-1:0]   wr_data_i,
  output logic [NCH-1:0] tick_o,
  output logic [NCH-1:0] sq_o,
  output logic [NCH-1:0] pend_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [NCH-1:0][W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0][W-1:0] act_q, act_d;
  logic [NCH-1:0][W-1:0] sh_q, sh_d;
  logic [NCH-1:0][W-1:0] nxt;
  logic [NCH-1:0]        pend_q, pend_d;
  logic [NCH-1:0]        sq_q, sq_d;
  logic [NCH-1:0]        tick_q, tick_d;
  logic [NCH-1:0]        hit;

  function automatic logic [W-1:0] reload(
    input logic [W-1:0] v
  );
    return (v == '0) ? '0 : v - ONE;
  endfunction

  always_comb begin
    hit = '0;
    nxt = '0;
    for (int c = 0; c < NCH; c++) begin
      hit[c] = wr_en_i && (wr_ch_i == 3'(c));
      nxt[c] = pend_q[c] ? sh_q[c] : act_q[c];
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    sh_d   = sh_q;
    pend_d = pend_q;
    sq_d   = sq_q;
    tick_d = '0;
    for (int c = 0; c < NCH; c++) begin
      if (sync_i) begin
        act_d[c]  = nxt[c];
        cnt_d[c]  = reload(nxt[c]);
        pend_d[c] = 1'b0;
        sq_d[c]   = 1'b0;
      end else if (act_q[c] == '0) begin
        // a stopped channel takes a new value immediately
        if (hit[c]) begin
          act_d[c] = wr_data_i;
          cnt_d[c] = reload(wr_data_i);
        end
      end else if (run_i) begin
        if (cnt_q[c] == '0) begin
          tick_d[c] = 1'b1;
          sq_d[c]   = ~sq_q[c];
          act_d[c]  = nxt[c];
          cnt_d[c]  = reload(nxt[c]);
          pend_d[c] = 1'b0;
        end else begin
          cnt_d[c] = cnt_q[c] - ONE;
        end
      end
      if (hit[c] && (sync_i || act_q[c] != '0)) begin
        sh_d[c]   = wr_data_i;
        pend_d[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        act_q[c] <= DIV_INIT[c*W +: W];
        cnt_q[c] <= reload(DIV_INIT[c*W +: W]);
      end
      sh_q   <= '0;
      pend_q <= '0;
      sq_q   <= '0;
      tick_q <= '0;
    end else begin
      act_q  <= act_d;
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      pend_q <= pend_d;
      sq_q   <= sq_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;
  assign sq_o   = sq_q;
  assign pend_o = pend_q;

endmodule

// File: tb/tb_clk_enable_gen.sv
// Scoreboard bench for clk_enable_gen.
// Expected per-cycle outputs are built from tick/pend timelines per scenario.
module tb_clk_enable_gen;

  localparam int W = 26;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         run_i = 1'b1;
  logic         sync_i = 1'b0;
  logic         wr_en_i = 1'b0;
  logic [2:0]   wr_ch_i = 3'd0;
  logic [W-1:0] wr_data_i = '0;
  logic [2:0]   tick_o, sq_o, pend_o;

  typedef struct {
    logic [2:0] tick;
    logic [2:0] sq;
    logic [2:0] pend;
  } exp_t;

  exp_t sb[$];
  bit   tkm [0:2][0:63];
  bit   pdm [0:2][0:63];
  int   sync_at;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  clk_enable_gen dut (
    .clk       (clk),
    .rst       (rst),
    .run_i     (run_i),
    .sync_i    (sync_i),
    .wr_en_i   (wr_en_i),
    .wr_ch_i   (wr_ch_i),
    .wr_data_i (wr_data_i),
    .tick_o    (tick_o),
    .sq_o      (sq_o),
    .pend_o    (pend_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exp();
    for (int c = 0; c < 3; c++)
      for (int k = 0; k < 64; k++) begin
        tkm[c][k] = 1'b0;
        pdm[c][k] = 1'b0;
      end
    sync_at = -1;
    sb.delete();
  endtask

  task automatic set_tk(input int c, input int first,
                        input int last, input int per);
    for (int k = first; k <= last; k += per)
      tkm[c][k] = 1'b1;
  endtask

  task automatic set_pd(input int c, input int a, input int b);
    for (int k = a; k <= b; k++)
      pdm[c][k] = 1'b1;
  endtask

  task automatic do_reset();
    wr_en_i = 1'b0;
    sync_i  = 1'b0;
    run_i   = 1'b1;
    rst     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_exp();
  endtask

  // sq follows the tick timeline: toggles per tick, cleared by sync
  task automatic push_window(input int n);
    logic [2:0] s;
    exp_t e;
    s = '0;
    for (int k = 1; k <= n; k++) begin
      if (k == sync_at) s = '0;
      e.tick = '0;
      e.pend = '0;
      for (int c = 0; c < 3; c++) begin
        if (tkm[c][k]) begin
          e.tick[c] = 1'b1;
          s[c] = ~s[c];
        end
        e.pend[c] = pdm[c][k];
      end
      e.sq = s;
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    do_reset();
    wr_en_i = 1'b1; wr_ch_i = 3'd1; wr_data_i = W'(7);
    step();
    wr_en_i = 1'b0;
    step();
    total++;
    if ({tick_o, sq_o, pend_o} !== 9'b001_001_010) begin
      bad++;
      $display("FAIL pre_reset got=%b want=%b",
               {tick_o, sq_o, pend_o}, 9'b001_001_010);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({tick_o, sq_o, pend_o} !== 9'b0) begin
      bad++;
      $display("FAIL async_reset got=%b want=0",
               {tick_o, sq_o, pend_o});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_exp();
    set_tk(0, 2, 24, 2);
    push_window(24);
    for (int k = 1; k <= 24; k++) begin
      step();
      e = sb.pop_front();
      total++;
      if ({tick_o, sq_o, pend_o} !== {e.tick, e.sq, e.pend}) begin
        bad++;
        $display("FAIL reset_run cyc=%0d got t=%b s=%b p=%b want t=%b s=%b p=%b",
                 k, tick_o, sq_o, pend_o, e.tick, e.sq, e.pend);
      end
    end
  endtask

  task automatic test_write_pend();
    exp_t e;
    do_reset();
    set_tk(0, 2, 4, 2);
    set_tk(0, 9, 20, 5);
    set_pd(0, 3, 3);
    set_pd(1, 4, 20);
    push_window(20);
    for (int k = 1; k <= 20; k++) begin
      step();
      e = sb.pop_front();
      total++;
      if ({tick_o, sq_o, pend_o} !== {e.tick, e.sq, e.pend}) begin
        bad++;
        $display("FAIL write_pend cyc=%0d got t=%b s=%b p=%b want t=%b s=%b p=%b",
                 k, tick_o, sq_o, pend_o, e.tick, e.sq, e.pend);
      end
      wr_en_i   = (k == 2 || k == 3);
      wr_ch_i   = (k == 2) ? 3'd0 : 3'd1;
      wr_data_i = W'(5);
    end
    wr_en_i = 1'b0;
  endtask

  task automatic test_stop_restart();
    exp_t e;
    do_reset();
    set_tk(0, 2, 4, 2);
    set_tk(0, 12, 20, 3);
    set_pd(0, 3, 3);
    push_window(20);
    for (int k = 1; k <= 20; k++) begin
      step();
      e = sb.pop_front();
      total++;
      if ({tick_o, sq_o, pend_o} !== {e.tick, e.sq, e.pend}) begin
        bad++;
        $display("FAIL stop_restart cyc=%0d got t=%b s=%b p=%b want t=%b s=%b p=%b",
                 k, tick_o, sq_o, pend_o, e.tick, e.sq, e.pend);
      end
      wr_en_i   = (k == 2 || k == 8);
      wr_ch_i   = 3'd0;
      wr_data_i = (k == 2) ? W'(0) : W'(3);
    end
    wr_en_i = 1'b0;
  endtask

  task automatic test_run_pause();
    exp_t e;
    do_reset();
    set_tk(0, 2, 4, 2);
    set_tk(0, 13, 20, 2);
    push_window(20);
    for (int k = 1; k <= 20; k++) begin
      step();
      e = sb.pop_front();
      total++;
      if ({tick_o, sq_o, pend_o} !== {e.tick, e.sq, e.pend}) begin
        bad++;
        $display("FAIL run_pause cyc=%0d got t=%b s=%b p=%b want t=%b s=%b p=%b",
                 k, tick_o, sq_o, pend_o, e.tick, e.sq, e.pend);
      end
      run_i = !(k >= 4 && k <= 10);
    end
    run_i = 1'b1;
  endtask

  task automatic test_sync();
    exp_t e;
    do_reset();
    set_tk(0, 2, 2, 1);
    set_tk(0, 8, 30, 4);
    set_tk(1, 10, 30, 6);
    set_pd(0, 1, 1);
    set_pd(1, 2, 3);
    sync_at = 4;
    push_window(30);
    wr_en_i = 1'b1; wr_ch_i = 3'd0; wr_data_i = W'(4);
    for (int k = 1; k <= 30; k++) begin
      step();
      e = sb.pop_front();
      total++;
      if ({tick_o, sq_o, pend_o} !== {e.tick, e.sq, e.pend}) begin
        bad++;
        $display("FAIL sync cyc=%0d got t=%b s=%b p=%b want t=%b s=%b p=%b",
                 k, tick_o, sq_o, pend_o, e.tick, e.sq, e.pend);
      end
      wr_en_i   = (k == 1);
      wr_ch_i   = 3'd1;
      wr_data_i = W'(6);
      sync_i    = (k == 3);
    end
    wr_en_i = 1'b0;
    sync_i  = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    set_tk(0, 2, 6, 2);
    set_tk(0, 9, 12, 3);
    set_tk(0, 13, 20, 1);
    set_pd(0, 4, 5);
    set_pd(0, 10, 11);
    push_window(20);
    for (int k = 1; k <= 20; k++) begin
      step();
      e = sb.pop_front();
      total++;
      if ({tick_o, sq_o, pend_o} !== {e.tick, e.sq, e.pend}) begin
        bad++;
        $display("FAIL back_to_back cyc=%0d got t=%b s=%b p=%b want t=%b s=%b p=%b",
                 k, tick_o, sq_o, pend_o, e.tick, e.sq, e.pend);
      end
      wr_en_i   = (k == 3 || k == 7 || k == 9 || k == 10);
      wr_ch_i   = (k == 7) ? 3'd7 : 3'd0;
      wr_data_i = (k == 3) ? W'(3) :
                  (k == 9) ? W'(7) : W'(1);
    end
    wr_en_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_pend();
    test_stop_restart();
    test_run_pause();
    test_sync();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
